// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types and constants for the GCD load client
//
// Holds the client FSM state encoding, the LFSR tap mask, the value used in
// place of an all-zero LFSR seed, and the one-step LFSR function shared by
// both operand generators.

package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } gcd_state_e;

    // Galois feedback mask applied when the bit shifted out is 1.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // An all-zero LFSR would lock up, so a zero seed is replaced by this.
    localparam logic [31:0] LFSR_ZERO_SUB = 32'h1;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] shifted;
        shifted = s >> 1;
        return s[0] ? (shifted ^ LFSR_TAPS) : shifted;
    endfunction

endpackage

// File: rtl/gcd_lfsr32.sv
// rtl/gcd_lfsr32.sv - 32-bit Galois LFSR with load, zero-seed substitution and step enable
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset, returns state to RESET_VAL
//   load   in   load seed (substituting LFSR_ZERO_SUB for a zero seed); wins over step
//   seed   in   32-bit seed value
//   step   in   advance one Galois step
//   state  out  current 32-bit LFSR state

import gcd_pkg::*;

module gcd_lfsr32 #(
    parameter logic [31:0] RESET_VAL = 32'h1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] state
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (seed == 32'h0) ? LFSR_ZERO_SUB : seed;
        end else if (step) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/gcd_load_client.sv
// rtl/gcd_load_client.sv - credit-limited pseudo-random traffic source for the GCD coprocessor
//
// On an accepted start, issues cfg_count pseudo-random operand pairs over the
// operands val/rdy interface with at most MAX_OUT requests outstanding, and
// folds every returned result into a rotate-XOR signature.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start              launch pulse, honoured in IDLE or DONE only
//   cfg_count          number of requests in the run (sampled on start)
//   cfg_seed           LFSR seed (sampled on start); B generator uses ~cfg_seed
//   busy / done        RUN or DRAIN / DONE
//   result_count       results received in the current or last run
//   signature          rotate-left-by-one then XOR of each received result
//   operands_*         operand pair stream towards the coprocessor
//   result_*           result stream from the coprocessor

import gcd_pkg::*;

module gcd_load_client #(
    parameter int W       = 32,
    parameter int CW      = 16,
    parameter int MAX_OUT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] cfg_count,
    input  logic [31:0]   cfg_seed,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] result_count,
    output logic [W-1:0]  signature,
    output logic          operands_val,
    output logic [W-1:0]  operands_bits_A,
    output logic [W-1:0]  operands_bits_B,
    input  logic          operands_rdy,
    input  logic          result_val,
    input  logic [W-1:0]  result_bits,
    output logic          result_rdy
);

    localparam int             IFW       = $clog2(MAX_OUT + 1);
    localparam logic [IFW-1:0] MAX_OUT_C = IFW'(MAX_OUT);

    gcd_state_e     state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  issued_q, issued_d;
    logic [CW-1:0]  result_count_q, result_count_d;
    logic [IFW-1:0] in_flight_q, in_flight_d;
    logic [W-1:0]   signature_q, signature_d;

    logic [31:0]    lfsr_a;
    logic [31:0]    lfsr_b;
    logic [31:0]    seed_b;
    logic [W-1:0]   a_low;
    logic [W-1:0]   b_low;

    logic           start_ok;
    logic           op_xfer;
    logic           res_xfer;

    assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
    assign op_xfer  = operands_val && operands_rdy;
    assign res_xfer = result_val && result_rdy;
    assign seed_b   = ~cfg_seed;

    // The LFSRs only move on an operand transfer, so the pair on the bus is
    // held steady for as long as the coprocessor stalls.
    gcd_lfsr32 #(
        .RESET_VAL (32'h0000_0001)
    ) u_lfsr_a (
        .clk   (clk),
        .reset (reset),
        .load  (start_ok),
        .seed  (cfg_seed),
        .step  (op_xfer),
        .state (lfsr_a)
    );

    gcd_lfsr32 #(
        .RESET_VAL (32'hFFFF_FFFF)
    ) u_lfsr_b (
        .clk   (clk),
        .reset (reset),
        .load  (start_ok),
        .seed  (seed_b),
        .step  (op_xfer),
        .state (lfsr_b)
    );

    // Narrow operands can still be zero even though the LFSR never is;
    // GCD with a zero operand is avoided by driving 1 instead.
    assign a_low = lfsr_a[W-1:0];
    assign b_low = lfsr_b[W-1:0];

    always_comb begin
        operands_bits_A = (a_low == '0) ? W'(1) : a_low;
        operands_bits_B = (b_low == '0) ? W'(1) : b_low;
    end

    // operands_val depends only on registered state. Once raised it can only
    // drop after a transfer: in_flight only falls on a result, issued only
    // rises on a transfer, and RUN is only left on the last transfer.
    always_comb begin
        busy         = (state_q == RUN) || (state_q == DRAIN);
        done         = (state_q == DONE);
        result_rdy   = (state_q == RUN) || (state_q == DRAIN);
        operands_val = (state_q == RUN) && (in_flight_q < MAX_OUT_C) &&
                       (issued_q != count_q);
    end

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        issued_d       = issued_q;
        result_count_d = result_count_q;
        in_flight_d    = in_flight_q;
        signature_d    = signature_q;

        if (op_xfer) begin
            issued_d = issued_q + CW'(1);
        end

        if (res_xfer) begin
            result_count_d = result_count_q + CW'(1);
            signature_d    = {signature_q[W-2:0], signature_q[W-1]} ^ result_bits;
        end

        // A stray result with nothing outstanding is accepted but must not
        // wrap the credit counter.
        if (op_xfer && !res_xfer) begin
            in_flight_d = in_flight_q + IFW'(1);
        end else if (!op_xfer && res_xfer && (in_flight_q != '0)) begin
            in_flight_d = in_flight_q - IFW'(1);
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_d        = RUN;
                    count_d        = cfg_count;
                    issued_d       = '0;
                    result_count_d = '0;
                    in_flight_d    = '0;
                    signature_d    = '0;
                end
            end
            RUN: begin
                if (count_q == '0) begin
                    state_d = DONE;
                end else if (op_xfer && (issued_d == count_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (result_count_d == count_q) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            count_q        <= '0;
            issued_q       <= '0;
            result_count_q <= '0;
            in_flight_q    <= '0;
            signature_q    <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            issued_q       <= issued_d;
            result_count_q <= result_count_d;
            in_flight_q    <= in_flight_d;
            signature_q    <= signature_d;
        end
    end

    assign result_count = result_count_q;
    assign signature    = signature_q;

`ifndef SYNTHESIS
    // A result with no request outstanding means the coprocessor broke protocol.
    result_without_request: assert property (
        @(posedge clk) disable iff (reset) res_xfer |-> (in_flight_q != '0)
    );
`endif

endmodule
